// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: PC, single-outstanding imem requests, IF/ID register.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned flush targets halt fetch and flag the fault.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_flush,
  input  logic [31:0] pipe_flush_pc,
  input  logic        data_hazard,
  fetch_if.master     imem,
  output logic [31:0] if_id__ins,
  output logic [31:0] if_id__pc,
  output logic        if_id__data_hazard,
  output logic        if_id__ins_misaligned
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] buf_ins_q, buf_ins_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] ifid_ins_q, ifid_ins_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_hz_q, ifid_hz_d;

  logic        req;
  logic [31:0] addr;
  logic [31:0] flush_tgt;
  logic        halted;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        halt_q, halt_d;
  logic        mis_q, mis_d;
  logic        flush_bad;

  assign flush_tgt = pipe_flush_pc;
  assign flush_bad = |pipe_flush_pc[1:0];
  assign halted    = halt_q;
  assign if_id__ins_misaligned = mis_q;
`else
  assign flush_tgt = pipe_flush_pc & 32'hFFFF_FFFC;
  assign halted    = 1'b0;
  assign if_id__ins_misaligned = 1'b0;
`endif

  assign req  = (state_q != S_IDLE);
  assign addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  assign if_id__ins         = ifid_ins_q;
  assign if_id__pc          = ifid_pc_q;
  assign if_id__data_hazard = ifid_hz_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_ins_d    = buf_ins_q;
    buf_pc_d     = buf_pc_q;
    buf_valid_d  = buf_valid_q;
    ifid_ins_d   = ifid_ins_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_hz_d    = data_hazard & ~pipe_flush;
`ifdef FETCH_MISALIGN_TRAP_EN
    halt_d       = halt_q;
    mis_d        = mis_q;
`endif

    if (pipe_flush) begin
      // Flush wins over stall and ack; an unacked request must be drained so its late ack is not mistaken for the target.
      ifid_ins_d   = NOP_INS;
      ifid_pc_d    = flush_tgt;
      buf_valid_d  = 1'b0;
      pc_d         = flush_tgt;
      drain_addr_d = addr;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (flush_bad) begin
        state_d = S_IDLE;
        halt_d  = 1'b1;
        mis_d   = 1'b1;
      end else begin
        halt_d  = 1'b0;
        mis_d   = 1'b0;
        state_d = (req && !imem.imem_ack) ? S_DRAIN : S_FETCH;
      end
`else
      state_d = (req && !imem.imem_ack) ? S_DRAIN : S_FETCH;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (buf_valid_q) begin
            if (!data_hazard) begin
              ifid_ins_d  = buf_ins_q;
              ifid_pc_d   = buf_pc_q;
              buf_valid_d = 1'b0;
              state_d     = S_FETCH;
            end
          end else if (!halted) begin
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (data_hazard) begin
            // IF/ID is frozen, so a word arriving now parks in the skid buffer.
            if (imem.imem_ack) begin
              buf_ins_d   = imem.imem_rdata;
              buf_pc_d    = pc_q;
              buf_valid_d = 1'b1;
              pc_d        = pc_q + 32'd4;
              state_d     = S_IDLE;
            end
          end else if (imem.imem_ack) begin
            ifid_ins_d = imem.imem_rdata;
            ifid_pc_d  = pc_q;
            pc_d       = pc_q + 32'd4;
          end else begin
            ifid_ins_d = NOP_INS;
            ifid_pc_d  = pc_q;
          end
        end
        S_DRAIN: begin
          ifid_ins_d = NOP_INS;
          if (imem.imem_ack) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      buf_ins_q    <= '0;
      buf_pc_q     <= '0;
      buf_valid_q  <= 1'b0;
      ifid_ins_q   <= NOP_INS;
      ifid_pc_q    <= RESET_PC;
      ifid_hz_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_ins_q    <= buf_ins_d;
      buf_pc_q     <= buf_pc_d;
      buf_valid_q  <= buf_valid_d;
      ifid_ins_q   <= ifid_ins_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_hz_q    <= ifid_hz_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      halt_q <= halt_d;
      mis_q  <= mis_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch; memory returns addr ^ 32'hA5A5_0000 when acking.
module tb_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        pipe_flush;
  logic [31:0] pipe_flush_pc;
  logic        data_hazard;
  logic        ack_en;
  logic [31:0] if_id__ins;
  logic [31:0] if_id__pc;
  logic        if_id__data_hazard;
  logic        if_id__ins_misaligned;

  int unsigned n_cmp;
  int unsigned n_bad;

  fetch_if bus ();

  assign bus.imem_ack   = ack_en;
  assign bus.imem_rdata = bus.imem_addr ^ KEY;

  fetch #(
    .RESET_PC(32'h0000_0000),
    .NOP_INS (32'h0000_0013)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pipe_flush           (pipe_flush),
    .pipe_flush_pc        (pipe_flush_pc),
    .data_hazard          (data_hazard),
    .imem                 (bus),
    .if_id__ins           (if_id__ins),
    .if_id__pc            (if_id__pc),
    .if_id__data_hazard   (if_id__data_hazard),
    .if_id__ins_misaligned(if_id__ins_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    pipe_flush    = 1'b0;
    pipe_flush_pc = '0;
    data_hazard   = 1'b0;
    ack_en        = 1'b0;
    tick();
    tick();

    chk("rst_req",  {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_ins",  if_id__ins, NOP);
    chk("rst_pc",   if_id__pc, 32'h0);
    chk("rst_hz",   {31'd0, if_id__data_hazard}, 32'd0);
    chk("rst_mis",  {31'd0, if_id__ins_misaligned}, 32'd0);

    // Back-to-back fetch after reset release
    rst = 1'b0; ack_en = 1'b1;
    tick();
    chk("e1_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("e1_addr", bus.imem_addr, 32'h0);
    chk("e1_ins",  if_id__ins, NOP);
    tick();
    chk("e2_ins",  if_id__ins, 32'hA5A5_0000);
    chk("e2_pc",   if_id__pc, 32'h0);
    chk("e2_addr", bus.imem_addr, 32'h4);
    tick();
    chk("e3_ins",  if_id__ins, 32'hA5A5_0004);
    chk("e3_pc",   if_id__pc, 32'h4);

    // Three wait states at PC 8
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_ins",  if_id__ins, NOP);
      chk("wait_pc",   if_id__pc, 32'h8);
      chk("wait_addr", bus.imem_addr, 32'h8);
      chk("wait_req",  {31'd0, bus.imem_req}, 32'd1);
    end
    ack_en = 1'b1;
    tick();
    chk("w_ins",  if_id__ins, 32'hA5A5_0008);
    chk("w_pc",   if_id__pc, 32'h8);
    chk("w_addr", bus.imem_addr, 32'hC);

    // Two-cycle stall while PC 12 is acked
    data_hazard = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_ins", if_id__ins, 32'hA5A5_0008);
      chk("st_pc",  if_id__pc, 32'h8);
      chk("st_hz",  {31'd0, if_id__data_hazard}, 32'd1);
      chk("st_req", {31'd0, bus.imem_req}, 32'd0);
    end
    data_hazard = 1'b0;
    tick();
    chk("rel_ins",  if_id__ins, 32'hA5A5_000C);
    chk("rel_pc",   if_id__pc, 32'hC);
    chk("rel_hz",   {31'd0, if_id__data_hazard}, 32'd0);
    chk("rel_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("rel_addr", bus.imem_addr, 32'h10);
    tick();
    chk("p16_ins", if_id__ins, 32'hA5A5_0010);
    chk("p16_pc",  if_id__pc, 32'h10);

    // Flush to 0x100 with PC 20 outstanding
    ack_en = 1'b0;
    tick();
    chk("p20_wait", if_id__ins, NOP);
    pipe_flush = 1'b1; pipe_flush_pc = 32'h100;
    tick();
    pipe_flush = 1'b0;
    chk("dr_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("dr_addr", bus.imem_addr, 32'h14);
    chk("dr_ins",  if_id__ins, NOP);
    chk("dr_pc",   if_id__pc, 32'h100);
    ack_en = 1'b1;
    tick();
    chk("dr_disc", if_id__ins, NOP);
    chk("dr_next", bus.imem_addr, 32'h100);
    tick();
    chk("t100_ins", if_id__ins, 32'hA5A5_0100);
    chk("t100_pc",  if_id__pc, 32'h100);

    // Flush and hazard together
    pipe_flush = 1'b1; pipe_flush_pc = 32'h100; data_hazard = 1'b1;
    tick();
    pipe_flush = 1'b0; data_hazard = 1'b0;
    chk("fh_ins",  if_id__ins, NOP);
    chk("fh_hz",   {31'd0, if_id__data_hazard}, 32'd0);
    chk("fh_addr", bus.imem_addr, 32'h100);
    chk("fh_req",  {31'd0, bus.imem_req}, 32'd1);
    tick();
    chk("fh_data", if_id__ins, 32'hA5A5_0100);

    // Misaligned flush target
    pipe_flush = 1'b1; pipe_flush_pc = 32'h102;
    tick();
    pipe_flush = 1'b0;
    chk("ma_ins", if_id__ins, NOP);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_mis", {31'd0, if_id__ins_misaligned}, 32'd1);
    chk("ma_req", {31'd0, bus.imem_req}, 32'd0);
    chk("ma_pc",  if_id__pc, 32'h102);
    data_hazard = 1'b1;
    tick();
    data_hazard = 1'b0;
    tick();
    chk("ma_hold", {31'd0, if_id__ins_misaligned}, 32'd1);
    chk("ma_req2", {31'd0, bus.imem_req}, 32'd0);
`else
    chk("ma_mis",  {31'd0, if_id__ins_misaligned}, 32'd0);
    chk("ma_addr", bus.imem_addr, 32'h100);
    chk("ma_pc",   if_id__pc, 32'h100);
    tick();
    chk("ma_data", if_id__ins, 32'hA5A5_0100);
`endif
    pipe_flush = 1'b1; pipe_flush_pc = 32'h200;
    tick();
    pipe_flush = 1'b0;
    chk("rf_mis",  {31'd0, if_id__ins_misaligned}, 32'd0);
    chk("rf_addr", bus.imem_addr, 32'h200);
    chk("rf_req",  {31'd0, bus.imem_req}, 32'd1);
    tick();
    chk("rf_data", if_id__ins, 32'hA5A5_0200);

    // Reset asserted while draining
    ack_en = 1'b0; pipe_flush = 1'b1; pipe_flush_pc = 32'h300;
    tick();
    pipe_flush = 1'b0;
    chk("rd_addr", bus.imem_addr, 32'h204);
    rst = 1'b1; ack_en = 1'b1;
    tick();
    chk("rd_req",  {31'd0, bus.imem_req}, 32'd0);
    chk("rd_addr0", bus.imem_addr, 32'h0);
    chk("rd_ins",  if_id__ins, NOP);
    chk("rd_pc",   if_id__pc, 32'h0);
    rst = 1'b0;
    tick();
    chk("rd_fetch", bus.imem_addr, 32'h0);
    tick();
    chk("rd_data", if_id__ins, 32'hA5A5_0000);

    // PC wrap at top of address space
    pipe_flush = 1'b1; pipe_flush_pc = 32'hFFFF_FFFC;
    tick();
    pipe_flush = 1'b0;
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_ins",  if_id__ins, 32'h5A5A_FFFC);
    chk("wr_pc",   if_id__pc, 32'hFFFF_FFFC);
    chk("wr_wrap", bus.imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
